xram_wait_ctrl: RTL and testbench
=================================

// Module: xram_wait_ctrl
// PURPOSE
// - Downstream neighbour of the Xram two-port mux: accepts its single RAM request stream and drives a synchronous
//   single-port SRAM macro.
// - Inserts programmable read/write wait states by withholding ram_rready_o/ram_wready_o, so the mux's grant is delayed.
// - The mux's rvalid (grant + 1 cycle) therefore still lands on valid read data.
// - Holds read data stable after the rvalid cycle until the next read completes.
// PARAMETERS
// - ADDR_WIDTH      32  byte address width from mux
// - DATA_WIDTH      32  RAM word width (32/64/128)
// - RAM_ADDR_WIDTH  14  SRAM word-address width
// - WAIT_W          4   width of wait-state counters/config
// - RD_WAIT_DEF     2   reset value of read wait states
// - WR_WAIT_DEF     1   reset value of write wait states
// PORTS
// - clk             in   1               clock
// - rst_n           in   1               async reset, active low
// - cfg_rd_wait_i   in   WAIT_W          requested read wait states
// - cfg_wr_wait_i   in   WAIT_W          requested write wait states
// - ram_en_i        in   1               request valid (from mux ram_en_o)
// - ram_addr_i      in   ADDR_WIDTH      byte address
// - ram_we_i        in   1               1=write
// - ram_be_i        in   DATA_WIDTH/8    byte enables
// - ram_wdata_i     in   DATA_WIDTH      write data
// - ram_rready_o    out  1               read may be granted this cycle
// - ram_wready_o    out  1               write may be granted this cycle
// - ram_rdata_o     out  DATA_WIDTH      read data (valid cycle after read grant, then held)
// - addr_err_o      out  1               1-cycle pulse: granted access outside SRAM range
// - sram_cs_o       out  1               macro chip select
// - sram_we_o       out  1               macro write enable
// - sram_addr_o     out  RAM_ADDR_WIDTH  macro word address
// - sram_be_o       out  DATA_WIDTH/8    macro byte enables
// - sram_wdata_o    out  DATA_WIDTH      macro write data
// - sram_rdata_i    in   DATA_WIDTH      macro read data (1-cycle synchronous read)
// BEHAVIOUR
// - Config shadow regs rd_wait_q/wr_wait_q.
//   - Reset to RD_WAIT_DEF/WR_WAIT_DEF.
//   - Load cfg_*_i only in cycles where cnt_q==0 and ram_en_i==0, so a change never alters an in-progress wait.
// - Wait counter cnt_q (WAIT_W bits), reset 0.
//   - cnt_q increments each cycle ram_en_i=1 and no grant occurs; saturates at all-ones.
//   - Clears on grant or when ram_en_i=0.
//   - The counter is shared: if the mux switches ports mid-wait, accrued cycles carry over to the new request (intended).
// - FSM (encoded by cnt_q):
//   - IDLE: cnt_q==0, no request.
//   - WAIT: en, count below required wait.
//   - GRANT: en, cnt_q >= required wait.
//   - GRANT -> IDLE next cycle; back-to-back requests each pay their full wait.
// - ram_rready_o = (cnt_q >= rd_wait_q); ram_wready_o = (cnt_q >= wr_wait_q).
//   - Both are combinational and independent of ram_en_i.
//   - Wait value 0 gives zero-wait operation: ready is high from reset and a grant occurs in the first request cycle.
// - grant = ram_en_i & (ram_we_i ? ram_wready_o : ram_rready_o).
// - SRAM drive:
//   - sram_cs_o = grant & in_range.
//   - sram_we_o, sram_be_o, sram_wdata_o pass through.
//   - sram_addr_o = ram_addr_i[RAM_ADDR_WIDTH+$clog2(DATA_WIDTH/8)-1 : $clog2(DATA_WIDTH/8)].
// - in_range: all ram_addr_i bits above the SRAM field are 0.
// - Out-of-range grant: access is suppressed, but the grant still completes (no deadlock).
//   - addr_err_o pulses high in the grant cycle.
//   - A read returns all zeros.
// - Read data:
//   - rd_pend_q <= grant & ~ram_we_i; rd_oor_q records an out-of-range read.
//   - In the rvalid cycle (rd_pend_q=1), ram_rdata_o = rd_oor_q ? '0 : sram_rdata_i; hold_q captures that value.
//   - Otherwise ram_rdata_o = hold_q.
//   - hold_q resets to 0; writes never modify hold_q.
// - Reset values: cnt_q=0, rd_pend_q=0, hold_q=0, so ram_rdata_o=0 and sram_cs_o=0 in reset.
//   - ram_rready_o/ram_wready_o in reset = (RD_WAIT_DEF==0)/(WR_WAIT_DEF==0).
// - Reset mid-wait discards the accrued count.
// - Reset in the rvalid cycle forces ram_rdata_o=0; the mux rvalid also resets, so no data is lost.
// - Simultaneous cfg change and request: the change is deferred until the next idle cycle.
// STRUCTURE
// - Package xram_pkg: typedef wait_cnt_t (logic [WAIT_W-1:0]), localparam BYTE_OFF = $clog2(DATA_WIDTH/8).
// - Sub-module xram_rdata_hold: rd_pend_q/rd_oor_q/hold_q with the output mux.
// - Counter, config shadow and grant logic stay in the top module.
// TESTING
// - rd_wait=2, single read of addr 0x10 (word 4 = 0xCAFE0001): ready is low for 2 cycles, the grant is on the 3rd,
//   and ram_rdata_o=0xCAFE0001 the next cycle and stays held.
// - rd_wait=0, wr_wait=0: back-to-back write of 0x12345678 to addr 0x8, then read of 0x8: cs every cycle, read returns 0x12345678.
// - wr_wait=3, write with ram_en_i dropped after 2 cycles, re-raised: count restarts; the grant comes 3 cycles after re-raise.
// - Access to addr 1<<(RAM_ADDR_WIDTH+2): sram_cs_o=0, addr_err_o=1 for 1 cycle; a read returns 0x0; a write leaves SRAM unchanged.
// - cfg_rd_wait_i changed 1->4 during a WAIT state: the current read uses 1, the next read uses 4.
// - rst_n asserted while cnt_q=2 and again in an rvalid cycle: cnt_q=0, ram_rdata_o=0, readies return to reset values.

Source files
------------

// File: rtl/xram_pkg.sv
// Shared types and constants for the Xram wait-state controller.
package xram_pkg;

  localparam int unsigned XRAM_WAIT_W     = 4;
  localparam int unsigned XRAM_DATA_WIDTH = 32;
  localparam int unsigned BYTE_OFF        = $clog2(XRAM_DATA_WIDTH / 8);

  typedef logic [XRAM_WAIT_W-1:0] wait_cnt_t;

  // Byte-offset bits within one RAM word for a given word width.
  function automatic int unsigned byte_off(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/xram_rdata_hold.sv
// Read-data return path: presents SRAM data in the rvalid cycle and holds it until the next read.
module xram_rdata_hold
  import xram_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = XRAM_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  rd_grant_i,
  input  logic                  rd_oor_i,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);

  logic                  rd_pend_q;
  logic                  rd_oor_q;
  logic [DATA_WIDTH-1:0] hold_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_q <= 1'b0;
      rd_oor_q  <= 1'b0;
      hold_q    <= '0;
    end else begin
      rd_pend_q <= rd_grant_i;
      rd_oor_q  <= rd_oor_i;
      if (rd_pend_q) begin
        hold_q <= rdata_o;
      end
    end
  end

  // Out-of-range reads never touched the macro, so its output is stale and masked.
  always_comb begin
    rdata_o = hold_q;
    if (rd_pend_q) begin
      rdata_o = rd_oor_q ? '0 : sram_rdata_i;
    end
  end

endmodule

// File: rtl/xram_wait_ctrl.sv
// Wait-state controller between the Xram request mux and a single-port synchronous SRAM macro.
module xram_wait_ctrl
  import xram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH     = 32,
  parameter int unsigned DATA_WIDTH     = XRAM_DATA_WIDTH,
  parameter int unsigned RAM_ADDR_WIDTH = 14,
  parameter int unsigned WAIT_W         = XRAM_WAIT_W,
  parameter int unsigned RD_WAIT_DEF    = 2,
  parameter int unsigned WR_WAIT_DEF    = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [WAIT_W-1:0]         cfg_rd_wait_i,
  input  logic [WAIT_W-1:0]         cfg_wr_wait_i,
  input  logic                      ram_en_i,
  input  logic [ADDR_WIDTH-1:0]     ram_addr_i,
  input  logic                      ram_we_i,
  input  logic [DATA_WIDTH/8-1:0]   ram_be_i,
  input  logic [DATA_WIDTH-1:0]     ram_wdata_i,
  output logic                      ram_rready_o,
  output logic                      ram_wready_o,
  output logic [DATA_WIDTH-1:0]     ram_rdata_o,
  output logic                      addr_err_o,
  output logic                      sram_cs_o,
  output logic                      sram_we_o,
  output logic [RAM_ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH/8-1:0]   sram_be_o,
  output logic [DATA_WIDTH-1:0]     sram_wdata_o,
  input  logic [DATA_WIDTH-1:0]     sram_rdata_i
);

  localparam int unsigned BOFF = byte_off(DATA_WIDTH);
  localparam int unsigned TOP  = RAM_ADDR_WIDTH + BOFF;

  logic [WAIT_W-1:0] cnt_q, cnt_d;
  logic [WAIT_W-1:0] rd_wait_q, wr_wait_q;
  logic              grant;
  logic              in_range;
  logic              idle;

  assign ram_rready_o = (cnt_q >= rd_wait_q);
  assign ram_wready_o = (cnt_q >= wr_wait_q);
  assign grant        = ram_en_i & (ram_we_i ? ram_wready_o : ram_rready_o);
  assign in_range     = ((ram_addr_i >> TOP) == '0);
  assign idle         = (cnt_q == '0) & ~ram_en_i;

  // Counter is shared by both ports, so a port switch mid-wait keeps the accrued cycles.
  always_comb begin
    cnt_d = cnt_q;
    if (!ram_en_i || grant) begin
      cnt_d = '0;
    end else if (cnt_q != '1) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q     <= '0;
      rd_wait_q <= WAIT_W'(RD_WAIT_DEF);
      wr_wait_q <= WAIT_W'(WR_WAIT_DEF);
    end else begin
      cnt_q <= cnt_d;
      // Config only moves while idle so an in-flight wait keeps its length.
      if (idle) begin
        rd_wait_q <= cfg_rd_wait_i;
        wr_wait_q <= cfg_wr_wait_i;
      end
    end
  end

  assign sram_cs_o    = grant & in_range;
  assign sram_we_o    = ram_we_i;
  assign sram_addr_o  = ram_addr_i[TOP-1:BOFF];
  assign sram_be_o    = ram_be_i;
  assign sram_wdata_o = ram_wdata_i;
  assign addr_err_o   = grant & ~in_range;

  xram_rdata_hold #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_rdata_hold (
    .clk         (clk),
    .rst_n       (rst_n),
    .rd_grant_i  (grant & ~ram_we_i),
    .rd_oor_i    (~in_range),
    .sram_rdata_i(sram_rdata_i),
    .rdata_o     (ram_rdata_o)
  );

endmodule

// File: tb/tb_xram_wait_ctrl.sv
// Self-checking bench for xram_wait_ctrl with an SRAM model and a transaction-level reference.
module tb_xram_wait_ctrl;

  localparam int RD_DEF = 2;
  localparam int WR_DEF = 1;

  logic        clk;
  logic        rst_n;
  logic [3:0]  cfg_rd_wait_i, cfg_wr_wait_i;
  logic        ram_en_i, ram_we_i;
  logic [31:0] ram_addr_i, ram_wdata_i;
  logic [3:0]  ram_be_i;
  logic        ram_rready_o, ram_wready_o, addr_err_o;
  logic [31:0] ram_rdata_o;
  logic        sram_cs_o, sram_we_o;
  logic [13:0] sram_addr_o;
  logic [3:0]  sram_be_o;
  logic [31:0] sram_wdata_o, sram_rdata_i;

  int n_chk  = 0;
  int n_pass = 0;

  xram_wait_ctrl #(
    .ADDR_WIDTH    (32),
    .DATA_WIDTH    (32),
    .RAM_ADDR_WIDTH(14),
    .WAIT_W        (4),
    .RD_WAIT_DEF   (RD_DEF),
    .WR_WAIT_DEF   (WR_DEF)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_rd_wait_i(cfg_rd_wait_i),
    .cfg_wr_wait_i(cfg_wr_wait_i),
    .ram_en_i     (ram_en_i),
    .ram_addr_i   (ram_addr_i),
    .ram_we_i     (ram_we_i),
    .ram_be_i     (ram_be_i),
    .ram_wdata_i  (ram_wdata_i),
    .ram_rready_o (ram_rready_o),
    .ram_wready_o (ram_wready_o),
    .ram_rdata_o  (ram_rdata_o),
    .addr_err_o   (addr_err_o),
    .sram_cs_o    (sram_cs_o),
    .sram_we_o    (sram_we_o),
    .sram_addr_o  (sram_addr_o),
    .sram_be_o    (sram_be_o),
    .sram_wdata_o (sram_wdata_o),
    .sram_rdata_i (sram_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM macro model: 1-cycle synchronous read, byte-masked write.
  logic [31:0] mem [int];
  logic [31:0] sram_w;
  always @(posedge clk) begin
    if (sram_cs_o) begin
      if (sram_we_o) begin
        sram_w = mem.exists(int'(sram_addr_o)) ? mem[int'(sram_addr_o)] : 32'h0;
        for (int b = 0; b < 4; b++) if (sram_be_o[b]) sram_w[8*b+:8] = sram_wdata_o[8*b+:8];
        mem[int'(sram_addr_o)] = sram_w;
      end else begin
        sram_rdata_i <= mem.exists(int'(sram_addr_o)) ? mem[int'(sram_addr_o)] : 32'h0;
      end
    end
  end

  // Reference: expected memory contents and wait configuration in effect.
  logic [31:0] ref_mem [int];
  int m_rd = RD_DEF;
  int m_wr = WR_DEF;
  bit m_busy = 1'b0;
  bit b_grant = 1'b0;

  // Config takes effect only at a clock edge with no request and no wait in progress.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rd   <= RD_DEF;
      m_wr   <= WR_DEF;
      m_busy <= 1'b0;
    end else begin
      if (!ram_en_i && !m_busy) begin
        m_rd <= int'(cfg_rd_wait_i);
        m_wr <= int'(cfg_wr_wait_i);
      end
      m_busy <= ram_en_i && !b_grant;
    end
  end

  function automatic logic [31:0] ref_rd(input int w);
    return ref_mem.exists(w) ? ref_mem[w] : 32'h0;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  // One complete access: counts wait cycles, checks SRAM drive, and for reads the returned/held data.
  task automatic access(input bit we, input logic [31:0] addr, input logic [3:0] be,
                        input logic [31:0] wd, input string nm);
    int n, exp_w, word;
    bit inr;
    logic [31:0] exp_rd, merged;
    @(negedge clk);
    ram_en_i = 1'b1; ram_we_i = we; ram_addr_i = addr; ram_be_i = be; ram_wdata_i = wd;
    exp_w = we ? m_wr : m_rd;
    inr   = (addr >> 16) == 32'h0;
    word  = int'(addr[15:2]);
    #1;
    n = 0;
    while (!(we ? ram_wready_o : ram_rready_o) && n <= 40) begin
      @(negedge clk); #1; n++;
    end
    n_chk++;
    if (n !== exp_w) $display("FAIL %s wait: got %0d cycles, expected %0d", nm, n, exp_w);
    else n_pass++;
    n_chk++;
    if (sram_cs_o !== inr) $display("FAIL %s cs: got %b expected %b", nm, sram_cs_o, inr);
    else n_pass++;
    n_chk++;
    if (addr_err_o !== !inr) $display("FAIL %s addr_err: got %b expected %b", nm, addr_err_o, !inr);
    else n_pass++;
    if (inr) begin
      n_chk++;
      if (sram_addr_o !== word[13:0])
        $display("FAIL %s sram_addr: got %h expected %h", nm, sram_addr_o, word[13:0]);
      else n_pass++;
    end
    b_grant = 1'b1;
    @(posedge clk); #1;
    ram_en_i = 1'b0; b_grant = 1'b0;
    if (we && inr) begin
      merged = ref_rd(word);
      for (int b = 0; b < 4; b++) if (be[b]) merged[8*b+:8] = wd[8*b+:8];
      ref_mem[word] = merged;
    end
    if (!we) begin
      exp_rd = inr ? ref_rd(word) : 32'h0;
      @(negedge clk);
      n_chk++;
      if (ram_rdata_o !== exp_rd) $display("FAIL %s rdata: got %h expected %h", nm, ram_rdata_o, exp_rd);
      else n_pass++;
      n_chk++;
      if (addr_err_o !== 1'b0) $display("FAIL %s err_pulse: got %b expected 0", nm, addr_err_o);
      else n_pass++;
      @(negedge clk);
      n_chk++;
      if (ram_rdata_o !== exp_rd) $display("FAIL %s hold: got %h expected %h", nm, ram_rdata_o, exp_rd);
      else n_pass++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (ram_rready_o !== (RD_DEF == 0)) $display("FAIL reset rready: got %b expected %b", ram_rready_o, RD_DEF == 0);
    else n_pass++;
    n_chk++;
    if (ram_wready_o !== (WR_DEF == 0)) $display("FAIL reset wready: got %b expected %b", ram_wready_o, WR_DEF == 0);
    else n_pass++;
    n_chk++;
    if (ram_rdata_o !== 32'h0) $display("FAIL reset rdata: got %h expected 0", ram_rdata_o);
    else n_pass++;
    n_chk++;
    if (sram_cs_o !== 1'b0 || addr_err_o !== 1'b0)
      $display("FAIL reset cs_err: got %b%b expected 00", sram_cs_o, addr_err_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_read_wait();
    mem[4] = 32'hCAFE0001; ref_mem[4] = 32'hCAFE0001;
    cfg_rd_wait_i = 4'd2;
    idle(2);
    access(1'b0, 32'h10, 4'hF, 32'h0, "rd_wait2");
  endtask

  task automatic test_zero_wait_b2b();
    cfg_rd_wait_i = 4'd0; cfg_wr_wait_i = 4'd0;
    idle(2);
    access(1'b1, 32'h8, 4'hF, 32'h12345678, "b2b_wr");
    access(1'b0, 32'h8, 4'hF, 32'h0, "b2b_rd");
  endtask

  task automatic test_wr_drop();
    cfg_wr_wait_i = 4'd3; cfg_rd_wait_i = 4'd2;
    idle(2);
    @(negedge clk);
    ram_en_i = 1'b1; ram_we_i = 1'b1; ram_addr_i = 32'h20; ram_be_i = 4'hF; ram_wdata_i = 32'hA5A5_0F0F;
    for (int i = 0; i < 2; i++) begin
      #1;
      n_chk++;
      if (ram_wready_o !== 1'b0 || sram_cs_o !== 1'b0)
        $display("FAIL drop_wait%0d: got wready=%b cs=%b expected 0 0", i, ram_wready_o, sram_cs_o);
      else n_pass++;
      @(negedge clk);
    end
    ram_en_i = 1'b0;
    access(1'b1, 32'h20, 4'hF, 32'hA5A5_0F0F, "drop_rewr");
    access(1'b0, 32'h20, 4'hF, 32'h0, "drop_rd");
  endtask

  task automatic test_oor();
    access(1'b0, 32'h1 << 16, 4'hF, 32'h0, "oor_rd");
    access(1'b1, (32'h1 << 16) | 32'h10, 4'hF, 32'hDEADBEEF, "oor_wr");
    access(1'b0, 32'h10, 4'hF, 32'h0, "oor_chk");
  endtask

  task automatic test_cfg_change();
    cfg_rd_wait_i = 4'd1;
    idle(2);
    @(negedge clk);
    ram_en_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h8; ram_be_i = 4'hF;
    #1;
    n_chk++;
    if (ram_rready_o !== 1'b0) $display("FAIL cfg_wait: got %b expected 0", ram_rready_o);
    else n_pass++;
    cfg_rd_wait_i = 4'd4;
    @(negedge clk); #1;
    n_chk++;
    if (ram_rready_o !== 1'b1) $display("FAIL cfg_old_used: got %b expected 1", ram_rready_o);
    else n_pass++;
    b_grant = 1'b1;
    @(posedge clk); #1;
    ram_en_i = 1'b0; b_grant = 1'b0;
    @(negedge clk);
    n_chk++;
    if (ram_rdata_o !== ref_rd(2)) $display("FAIL cfg_rdata: got %h expected %h", ram_rdata_o, ref_rd(2));
    else n_pass++;
    access(1'b0, 32'h10, 4'hF, 32'h0, "cfg_new4");
  endtask

  task automatic test_reset_mid();
    cfg_rd_wait_i = 4'd3;
    idle(2);
    @(negedge clk);
    ram_en_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h10;
    repeat (2) @(negedge clk);
    #1;
    n_chk++;
    if (ram_rready_o !== 1'b0) $display("FAIL mid_wait: got %b expected 0", ram_rready_o);
    else n_pass++;
    rst_n = 1'b0; ram_en_i = 1'b0;
    #1;
    n_chk++;
    if (ram_rready_o !== (RD_DEF == 0) || ram_wready_o !== (WR_DEF == 0))
      $display("FAIL mid_rst_ready: got %b%b expected %b%b", ram_rready_o, ram_wready_o,
               RD_DEF == 0, WR_DEF == 0);
    else n_pass++;
    n_chk++;
    if (ram_rdata_o !== 32'h0) $display("FAIL mid_rst_rdata: got %h expected 0", ram_rdata_o);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    access(1'b0, 32'h10, 4'hF, 32'h0, "post_rst_rd");
    cfg_rd_wait_i = 4'd0;
    idle(2);
    @(negedge clk);
    ram_en_i = 1'b1; ram_we_i = 1'b0; ram_addr_i = 32'h8;
    #1;
    n_chk++;
    if (ram_rready_o !== 1'b1) $display("FAIL rv_grant: got %b expected 1", ram_rready_o);
    else n_pass++;
    b_grant = 1'b1;
    @(posedge clk); #1;
    ram_en_i = 1'b0; b_grant = 1'b0;
    @(negedge clk); #1;
    n_chk++;
    if (ram_rdata_o !== ref_rd(2)) $display("FAIL rv_data: got %h expected %h", ram_rdata_o, ref_rd(2));
    else n_pass++;
    rst_n = 1'b0;
    #1;
    n_chk++;
    if (ram_rdata_o !== 32'h0) $display("FAIL rv_rst_rdata: got %h expected 0", ram_rdata_o);
    else n_pass++;
    n_chk++;
    if (ram_rready_o !== (RD_DEF == 0)) $display("FAIL rv_rst_ready: got %b expected %b", ram_rready_o, RD_DEF == 0);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_random();
    logic [31:0] a;
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        cfg_rd_wait_i = 4'($urandom_range(0, 4));
        cfg_wr_wait_i = 4'($urandom_range(0, 4));
        idle(1 + $urandom_range(0, 1));
      end
      a = 32'($urandom_range(0, 31)) << 2;
      if ($urandom_range(0, 7) == 0) a = a | (32'($urandom_range(1, 255)) << 16);
      access($urandom_range(0, 1) == 1, a, 4'($urandom_range(0, 15)), $urandom, $sformatf("rnd%0d", i));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    cfg_rd_wait_i = 4'(RD_DEF); cfg_wr_wait_i = 4'(WR_DEF);
    ram_en_i = 1'b0; ram_we_i = 1'b0; ram_addr_i = '0; ram_be_i = '0; ram_wdata_i = '0;
    sram_rdata_i = '0;
    test_reset();
    test_read_wait();
    test_zero_wait_b2b();
    test_wr_drop();
    test_oor();
    test_cfg_change();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, %0d/%0d done", n_pass, n_chk);
    $fatal(1);
  end

endmodule
